// File: rtl/ula_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit.
// States, ALU ops, opcode/funct values and datapath mux codes.
package ula_ctrl_pkg;

  localparam int st_w = 4;

  typedef enum logic [st_w-1:0] {
    st_reset     = 4'd0,
    st_fetch     = 4'd1,
    st_fetch_wb  = 4'd2,
    st_decode    = 4'd3,
    st_r_exec    = 4'd4,
    st_r_wb      = 4'd5,
    st_addi_exec = 4'd6,
    st_addi_wb   = 4'd7,
    st_mem_addr  = 4'd8,
    st_lw_read   = 4'd9,
    st_lw_wb     = 4'd10,
    st_sw_write  = 4'd11,
    st_beq       = 4'd12,
    st_jump      = 4'd13,
    st_illegal   = 4'd14
  } state_t;

  localparam logic [2:0] alu_pass = 3'b000;
  localparam logic [2:0] alu_add  = 3'b001;
  localparam logic [2:0] alu_sub  = 3'b010;
  localparam logic [2:0] alu_and  = 3'b011;

  localparam logic [5:0] op_rtype = 6'h00;
  localparam logic [5:0] op_addi  = 6'h08;
  localparam logic [5:0] op_lw    = 6'h23;
  localparam logic [5:0] op_sw    = 6'h2b;
  localparam logic [5:0] op_beq   = 6'h04;
  localparam logic [5:0] op_j     = 6'h02;

  localparam logic [5:0] fn_add = 6'h20;
  localparam logic [5:0] fn_sub = 6'h22;
  localparam logic [5:0] fn_and = 6'h24;

  localparam logic       a_pc  = 1'b0;
  localparam logic       a_reg = 1'b1;

  localparam logic [1:0] b_reg    = 2'd0;
  localparam logic [1:0] b_four   = 2'd1;
  localparam logic [1:0] b_imm    = 2'd2;
  localparam logic [1:0] b_imm_sh = 2'd3;

  localparam logic [1:0] pcs_alu    = 2'd0;
  localparam logic [1:0] pcs_aluout = 2'd1;
  localparam logic [1:0] pcs_jump   = 2'd2;

  function automatic logic funct_ok(
    input logic [5:0] fn
  );
    return (fn == fn_add) ||
           (fn == fn_sub) ||
           (fn == fn_and);
  endfunction

  function automatic logic [2:0] funct_op(
    input logic [5:0] fn
  );
    logic [2:0] op;
    op = alu_add;
    if (fn == fn_sub) op = alu_sub;
    if (fn == fn_and) op = alu_and;
    return op;
  endfunction

endpackage

// File: rtl/ula_seq_ctrl_if.sv
// Control-to-datapath bundle: IR fields and zero flag in,
// mux selects and write enables out.
interface ula_seq_ctrl_if #(
  parameter int ST_W = 4
);
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic            zero;
  logic            ula_a_sel;
  logic [1:0]      ula_b_sel;
  logic [2:0]      ula_op;
  logic            pc_write;
  logic            pc_write_cond;
  logic [1:0]      pc_src;
  logic            ir_write;
  logic            ab_write;
  logic            aluout_write;
  logic            mem_read;
  logic            mem_write;
  logic            iord;
  logic            mdr_write;
  logic            reg_write;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            illegal_op;
  logic [ST_W-1:0] state_out;

  modport master (
    input  opcode, funct, zero,
    output ula_a_sel, ula_b_sel, ula_op,
    output pc_write, pc_write_cond, pc_src,
    output ir_write, ab_write, aluout_write,
    output mem_read, mem_write, iord,
    output mdr_write, reg_write, reg_dst,
    output mem_to_reg, illegal_op, state_out
  );

  modport slave (
    output opcode, funct, zero,
    input  ula_a_sel, ula_b_sel, ula_op,
    input  pc_write, pc_write_cond, pc_src,
    input  ir_write, ab_write, aluout_write,
    input  mem_read, mem_write, iord,
    input  mdr_write, reg_write, reg_dst,
    input  mem_to_reg, illegal_op, state_out
  );
endinterface

// File: rtl/ctrl_wait_cnt.sv
// Memory wait counter: counts cycles spent in one state,
// done when the access has been held for MEM_WAIT cycles.
module ctrl_wait_cnt #(
  parameter int MEM_WAIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic done
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= 4'd0;
    else              cnt <= cnt + 4'd1;
  end

  assign done = (cnt == 4'(MEM_WAIT - 1));

endmodule

// File: rtl/ula_seq_ctrl.sv
// Multicycle Moore control FSM for the MIPS-subset datapath:
// fetch, decode and per-class execute/writeback states.
module ula_seq_ctrl
  import ula_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int ST_W     = 4
) (
  input logic           clk,
  input logic           reset,
  ula_seq_ctrl_if.master bus
);

  state_t state_q;
  state_t state_d;
  logic   done;

  ctrl_wait_cnt #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk  (clk),
    .reset(reset),
    .clr  (state_d != state_q),
    .done (done)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= st_reset;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = st_fetch;
    case (state_q)
      st_reset:     state_d = st_fetch;
      st_fetch:     state_d = done ? st_fetch_wb : st_fetch;
      st_fetch_wb:  state_d = st_decode;
      st_decode: begin
        unique case (1'b1)
          bus.opcode == op_rtype:
            state_d = funct_ok(bus.funct) ? st_r_exec : st_illegal;
          bus.opcode == op_addi:
            state_d = st_addi_exec;
          bus.opcode == op_lw,
          bus.opcode == op_sw:
            state_d = st_mem_addr;
          bus.opcode == op_beq:
            state_d = st_beq;
          bus.opcode == op_j:
            state_d = st_jump;
          default:
            state_d = st_illegal;
        endcase
      end
      st_r_exec:    state_d = st_r_wb;
      st_addi_exec: state_d = st_addi_wb;
      st_mem_addr:
        state_d = (bus.opcode == op_sw) ? st_sw_write : st_lw_read;
      st_lw_read:   state_d = done ? st_lw_wb : st_lw_read;
      st_sw_write:  state_d = done ? st_fetch : st_sw_write;
      default:      state_d = st_fetch;
    endcase
  end

  always_comb begin
    bus.ula_a_sel     = a_pc;
    bus.ula_b_sel     = b_reg;
    bus.ula_op        = alu_pass;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = pcs_alu;
    bus.ir_write      = 1'b0;
    bus.ab_write      = 1'b0;
    bus.aluout_write  = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.mdr_write     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.illegal_op    = 1'b0;
    case (state_q)
      st_fetch: begin
        bus.mem_read = 1'b1;
      end
      st_fetch_wb: begin
        bus.ir_write  = 1'b1;
        bus.ula_b_sel = b_four;
        bus.ula_op    = alu_add;
        bus.pc_write  = 1'b1;
      end
      // branch target precomputed into ALUOut
      st_decode: begin
        bus.ab_write     = 1'b1;
        bus.ula_b_sel    = b_imm_sh;
        bus.ula_op       = alu_add;
        bus.aluout_write = 1'b1;
      end
      st_r_exec: begin
        bus.ula_a_sel    = a_reg;
        bus.ula_op       = funct_op(bus.funct);
        bus.aluout_write = 1'b1;
      end
      st_r_wb: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      st_addi_exec, st_mem_addr: begin
        bus.ula_a_sel    = a_reg;
        bus.ula_b_sel    = b_imm;
        bus.ula_op       = alu_add;
        bus.aluout_write = 1'b1;
      end
      st_addi_wb: begin
        bus.reg_write = 1'b1;
      end
      st_lw_read: begin
        bus.mem_read  = 1'b1;
        bus.iord      = 1'b1;
        bus.mdr_write = done;
      end
      st_lw_wb: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      st_sw_write: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      st_beq: begin
        bus.ula_a_sel     = a_reg;
        bus.ula_op        = alu_sub;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = pcs_aluout;
      end
      st_jump: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = pcs_jump;
      end
      st_illegal: begin
        bus.illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state_out = ST_W'(state_q);

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Directed scoreboard bench for ula_seq_ctrl, one DUT with
// MEM_WAIT=1 and one with MEM_WAIT=3.
module tb_ula_seq_ctrl;
  import ula_ctrl_pkg::*;

  typedef struct packed {
    logic       a;
    logic [1:0] b;
    logic [2:0] op;
    logic       pw;
    logic       pwc;
    logic [1:0] src;
    logic       ir;
    logic       ab;
    logic       ao;
    logic       mr;
    logic       mw;
    logic       iord;
    logic       mdr;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       ill;
  } ov_t;

  typedef struct packed {
    logic       which;
    logic [3:0] st;
    ov_t        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  always #5 clk = ~clk;

  ula_seq_ctrl_if #(.ST_W(4)) b1 ();
  ula_seq_ctrl_if #(.ST_W(4)) b3 ();

  ula_seq_ctrl #(.MEM_WAIT(1), .ST_W(4)) d1 (
    .clk  (clk),
    .reset(rst1),
    .bus  (b1.master)
  );

  ula_seq_ctrl #(.MEM_WAIT(3), .ST_W(4)) d3 (
    .clk  (clk),
    .reset(rst3),
    .bus  (b3.master)
  );

  exp_t  sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  string tag    = "reset";

  function automatic ov_t ref_out(
    input state_t s,
    input logic [2:0] rop,
    input logic mdr
  );
    ov_t o;
    o = '0;
    case (s)
      st_fetch:    o.mr = 1'b1;
      st_fetch_wb: begin
        o.ir = 1'b1; o.b = 2'd1; o.op = 3'b001; o.pw = 1'b1;
      end
      st_decode: begin
        o.ab = 1'b1; o.b = 2'd3; o.op = 3'b001; o.ao = 1'b1;
      end
      st_r_exec: begin
        o.a = 1'b1; o.op = rop; o.ao = 1'b1;
      end
      st_r_wb: begin
        o.rw = 1'b1; o.rd = 1'b1;
      end
      st_addi_exec, st_mem_addr: begin
        o.a = 1'b1; o.b = 2'd2; o.op = 3'b001; o.ao = 1'b1;
      end
      st_addi_wb:  o.rw = 1'b1;
      st_lw_read: begin
        o.mr = 1'b1; o.iord = 1'b1; o.mdr = mdr;
      end
      st_lw_wb: begin
        o.rw = 1'b1; o.m2r = 1'b1;
      end
      st_sw_write: begin
        o.mw = 1'b1; o.iord = 1'b1;
      end
      st_beq: begin
        o.a = 1'b1; o.op = 3'b010; o.pwc = 1'b1; o.src = 2'd1;
      end
      st_jump: begin
        o.pw = 1'b1; o.src = 2'd2;
      end
      st_illegal:  o.ill = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic ov_t obs(input logic w);
    ov_t o;
    if (w)
      o = {b3.ula_a_sel, b3.ula_b_sel, b3.ula_op, b3.pc_write,
           b3.pc_write_cond, b3.pc_src, b3.ir_write, b3.ab_write,
           b3.aluout_write, b3.mem_read, b3.mem_write, b3.iord,
           b3.mdr_write, b3.reg_write, b3.reg_dst, b3.mem_to_reg,
           b3.illegal_op};
    else
      o = {b1.ula_a_sel, b1.ula_b_sel, b1.ula_op, b1.pc_write,
           b1.pc_write_cond, b1.pc_src, b1.ir_write, b1.ab_write,
           b1.aluout_write, b1.mem_read, b1.mem_write, b1.iord,
           b1.mdr_write, b1.reg_write, b1.reg_dst, b1.mem_to_reg,
           b1.illegal_op};
    return o;
  endfunction

  task automatic push(
    input logic w,
    input state_t s,
    input logic [2:0] rop = 3'b000,
    input logic mdr = 1'b0
  );
    exp_t e;
    e.which = w;
    e.st    = s;
    e.o     = ref_out(s, rop, mdr);
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t       e;
    logic [3:0] gst;
    ov_t        go;
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    gst = e.which ? b3.state_out : b1.state_out;
    go  = obs(e.which);
    n_chk++;
    assert ({gst, go} === {e.st, e.o}) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s #%0d: state=%0d outs=%h, expected state=%0d outs=%h",
             tag, n_chk, gst, go, e.st, e.o);
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) step();
  endtask

  task automatic fetch_seq(input logic w, input int mw);
    for (int i = 1; i < mw; i++) push(w, st_fetch);
    push(w, st_fetch_wb);
    push(w, st_decode);
  endtask

  task automatic set_ir(
    input logic w,
    input logic [5:0] op,
    input logic [5:0] fn,
    input logic z
  );
    if (w) begin
      b3.opcode = op; b3.funct = fn; b3.zero = z;
    end else begin
      b1.opcode = op; b1.funct = fn; b1.zero = z;
    end
  endtask

  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    set_ir(1'b0, 6'h00, 6'h00, 1'b0);
    set_ir(1'b1, 6'h00, 6'h00, 1'b0);

    repeat (3) push(1'b0, st_reset);
    drain();
    rst1 = 1'b0;
    tag = "release";
    push(1'b0, st_fetch);
    drain();

    tag = "r_sub";
    set_ir(1'b0, 6'h00, 6'h22, 1'b0);
    fetch_seq(1'b0, 1);
    push(1'b0, st_r_exec, 3'b010);
    push(1'b0, st_r_wb);
    push(1'b0, st_fetch);
    drain();

    tag = "r_add";
    set_ir(1'b0, 6'h00, 6'h20, 1'b0);
    fetch_seq(1'b0, 1);
    push(1'b0, st_r_exec, 3'b001);
    push(1'b0, st_r_wb);
    push(1'b0, st_fetch);
    drain();

    tag = "r_and";
    set_ir(1'b0, 6'h00, 6'h24, 1'b0);
    fetch_seq(1'b0, 1);
    push(1'b0, st_r_exec, 3'b011);
    push(1'b0, st_r_wb);
    push(1'b0, st_fetch);
    drain();

    tag = "addi";
    set_ir(1'b0, 6'h08, 6'h3f, 1'b0);
    fetch_seq(1'b0, 1);
    push(1'b0, st_addi_exec);
    push(1'b0, st_addi_wb);
    push(1'b0, st_fetch);
    drain();

    tag = "sw1";
    set_ir(1'b0, 6'h2b, 6'h00, 1'b0);
    fetch_seq(1'b0, 1);
    push(1'b0, st_mem_addr);
    push(1'b0, st_sw_write);
    push(1'b0, st_fetch);
    drain();

    tag = "lw1";
    set_ir(1'b0, 6'h23, 6'h00, 1'b0);
    fetch_seq(1'b0, 1);
    push(1'b0, st_mem_addr);
    push(1'b0, st_lw_read, 3'b000, 1'b1);
    push(1'b0, st_lw_wb);
    push(1'b0, st_fetch);
    drain();

    tag = "beq_z1";
    set_ir(1'b0, 6'h04, 6'h00, 1'b1);
    fetch_seq(1'b0, 1);
    push(1'b0, st_beq);
    push(1'b0, st_fetch);
    drain();

    tag = "beq_z0";
    set_ir(1'b0, 6'h04, 6'h00, 1'b0);
    fetch_seq(1'b0, 1);
    push(1'b0, st_beq);
    push(1'b0, st_fetch);
    drain();

    tag = "jump";
    set_ir(1'b0, 6'h02, 6'h00, 1'b0);
    fetch_seq(1'b0, 1);
    push(1'b0, st_jump);
    push(1'b0, st_fetch);
    drain();

    tag = "ill_op";
    set_ir(1'b0, 6'h3f, 6'h20, 1'b0);
    fetch_seq(1'b0, 1);
    push(1'b0, st_illegal);
    push(1'b0, st_fetch);
    drain();

    tag = "ill_fn";
    set_ir(1'b0, 6'h00, 6'h27, 1'b0);
    fetch_seq(1'b0, 1);
    push(1'b0, st_illegal);
    push(1'b0, st_fetch);
    drain();

    tag = "w3_reset";
    push(1'b1, st_reset);
    drain();
    rst3 = 1'b0;
    push(1'b1, st_fetch);
    drain();

    tag = "w3_lw";
    set_ir(1'b1, 6'h23, 6'h00, 1'b0);
    fetch_seq(1'b1, 3);
    push(1'b1, st_mem_addr);
    push(1'b1, st_lw_read);
    push(1'b1, st_lw_read);
    push(1'b1, st_lw_read, 3'b000, 1'b1);
    push(1'b1, st_lw_wb);
    push(1'b1, st_fetch);
    drain();

    tag = "w3_sw";
    set_ir(1'b1, 6'h2b, 6'h00, 1'b0);
    fetch_seq(1'b1, 3);
    push(1'b1, st_mem_addr);
    repeat (3) push(1'b1, st_sw_write);
    push(1'b1, st_fetch);
    drain();

    tag = "w3_abort";
    set_ir(1'b1, 6'h23, 6'h00, 1'b0);
    fetch_seq(1'b1, 3);
    push(1'b1, st_mem_addr);
    push(1'b1, st_lw_read);
    push(1'b1, st_lw_read);
    drain();
    rst3 = 1'b1;
    push(1'b1, st_reset);
    push(1'b1, st_reset);
    drain();
    rst3 = 1'b0;
    push(1'b1, st_fetch);
    drain();

    tag = "w3_after";
    set_ir(1'b1, 6'h00, 6'h20, 1'b0);
    fetch_seq(1'b1, 3);
    push(1'b1, st_r_exec, 3'b001);
    push(1'b1, st_r_wb);
    push(1'b1, st_fetch);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
